board_tile_writer: RTL

Board tile store and update sequencer for the Tetris playfield. It consumes the falling piece's four block coordinates and palette colour from the game logic. On each change it erases the previously drawn cells and draws the new ones into a BOARD_W x BOARD_H tile array, one cell per frame_clk. The VGA colour mapper reads the array through a combinational port, so locked pieces stay on screen and only the moving piece is redrawn.

---
 rtl/board_tile_writer.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/board_tile_writer.sv
// Playfield tile store plus the erase/redraw sequencer for the falling piece.
// One cell write per frame_clk; the VGA side reads the array combinationally.
module board_tile_writer #(
    parameter int unsigned BOARD_W = 10,
    parameter int unsigned BOARD_H = 20,
    parameter int unsigned COLOR_W = 4
) (
    input  logic               frame_clk,
    input  logic               Reset,
    input  logic [27:0]        block_x_pos_i,
    input  logic [27:0]        block_y_pos_i,
    input  logic [COLOR_W-1:0] block_color_i,
    input  logic               piece_locked_i,
    input  logic [6:0]         rd_x_i,
    input  logic [6:0]         rd_y_i,
    output logic [COLOR_W-1:0] rd_color_o,
    output logic               busy_o,
    output logic               draw_done_o
);

    localparam int unsigned NumCells = BOARD_W * BOARD_H;
    localparam int unsigned AddrW    = $clog2(NumCells);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StErase = 2'd1;
    localparam logic [1:0] StDraw  = 2'd2;

    // Coordinate lane i of a packed 4 x 7-bit block vector.
    function automatic logic [6:0] lane(input logic [27:0] v, input logic [1:0] i);
        return v[7*i +: 7];
    endfunction

    logic [1:0]         state_q, state_d;
    logic [1:0]         idx_q, idx_d;
    logic [27:0]        lx_q, lx_d, ly_q, ly_d;
    logic [COLOR_W-1:0] lc_q, lc_d;
    logic [27:0]        sx_q, sx_d, sy_q, sy_d;
    logic [COLOR_W-1:0] sc_q, sc_d;
    logic               valid_q, valid_d;
    logic               lock_pend_q, lock_pend_d;
    logic               draw_done_q, draw_done_d;

    logic [COLOR_W-1:0] cells_q [NumCells];

    logic               change;
    logic               wr_req;
    logic               wr_en;
    logic [6:0]         wr_x, wr_y;
    logic [COLOR_W-1:0] wr_data;
    logic [AddrW-1:0]   wr_addr;
    logic               rd_in_range;
    logic [AddrW-1:0]   rd_addr;

    assign change = !valid_q
                  || (block_x_pos_i != lx_q)
                  || (block_y_pos_i != ly_q)
                  || (block_color_i != lc_q);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        lx_d        = lx_q;
        ly_d        = ly_q;
        lc_d        = lc_q;
        sx_d        = sx_q;
        sy_d        = sy_q;
        sc_d        = sc_q;
        valid_d     = valid_q;
        lock_pend_d = lock_pend_q;
        draw_done_d = 1'b0;
        wr_req      = 1'b0;
        wr_x        = '0;
        wr_y        = '0;
        wr_data     = '0;

        // A lock seen while sequencing is remembered for the next capture.
        if (piece_locked_i && (state_q != StIdle)) begin
            lock_pend_d = 1'b1;
        end

        case (state_q)
            StIdle: begin
                if (change) begin
                    sx_d        = block_x_pos_i;
                    sy_d        = block_y_pos_i;
                    sc_d        = block_color_i;
                    idx_d       = 2'd0;
                    lock_pend_d = 1'b0;
                    // Never erase cells that belong to a locked piece.
                    state_d     = (!valid_q || lock_pend_q || piece_locked_i) ? StDraw : StErase;
                end else if (piece_locked_i) begin
                    lock_pend_d = 1'b1;
                end
            end
            StErase: begin
                wr_req  = 1'b1;
                wr_x    = lane(lx_q, idx_q);
                wr_y    = lane(ly_q, idx_q);
                wr_data = '0;
                idx_d   = idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    state_d = StDraw;
                end
            end
            StDraw: begin
                wr_req  = 1'b1;
                wr_x    = lane(sx_q, idx_q);
                wr_y    = lane(sy_q, idx_q);
                wr_data = sc_q;
                idx_d   = idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    lx_d        = sx_q;
                    ly_d        = sy_q;
                    lc_d        = sc_q;
                    valid_d     = 1'b1;
                    draw_done_d = 1'b1;
                    state_d     = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                idx_d   = 2'd0;
            end
        endcase
    end

    // Off-board coordinates still take their cycle but write nothing.
    assign wr_en   = wr_req && (wr_x < 7'(BOARD_W)) && (wr_y < 7'(BOARD_H));
    assign wr_addr = AddrW'(wr_y) * AddrW'(BOARD_W) + AddrW'(wr_x);

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= StIdle;
            idx_q       <= 2'd0;
            lx_q        <= '0;
            ly_q        <= '0;
            lc_q        <= '0;
            sx_q        <= '0;
            sy_q        <= '0;
            sc_q        <= '0;
            valid_q     <= 1'b0;
            lock_pend_q <= 1'b0;
            draw_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            lx_q        <= lx_d;
            ly_q        <= ly_d;
            lc_q        <= lc_d;
            sx_q        <= sx_d;
            sy_q        <= sy_d;
            sc_q        <= sc_d;
            valid_q     <= valid_d;
            lock_pend_q <= lock_pend_d;
            draw_done_q <= draw_done_d;
        end
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < int'(NumCells); i++) begin
                cells_q[i] <= '0;
            end
        end else if (wr_en) begin
            cells_q[wr_addr] <= wr_data;
        end
    end

    assign rd_in_range = (rd_x_i < 7'(BOARD_W)) && (rd_y_i < 7'(BOARD_H));
    assign rd_addr     = AddrW'(rd_y_i) * AddrW'(BOARD_W) + AddrW'(rd_x_i);
    assign rd_color_o  = rd_in_range ? cells_q[rd_addr] : '0;

    assign busy_o      = (state_q != StIdle);
    assign draw_done_o = draw_done_q;

endmodule
